// File: rtl/booth_div_pkg.sv
// Shared types and constants for the booth_div sequential signed divider.
// Holds the FSM state enum, the iteration counter width helper and the divide-by-zero quotient pattern.
package booth_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } div_state_t;

    localparam int W_MAX = 16;

    // Quotient pattern reported for divide-by-zero (all ones, i.e. -1), sliced to W by the user.
    localparam logic [W_MAX-1:0] DZ_Q_ONES = '1;

    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/booth_div_if.sv
// Start/valid handshake bundle for booth_div; optional dz flag exists only with BOOTH_DIV_DZ_FLAG_EN.
// The master side issues operands, the slave side (the divider) returns busy/valid/results.
interface booth_div_if #(parameter int W = 4);
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         valid;
    logic [W-1:0] q;
    logic [W-1:0] r;
`ifdef BOOTH_DIV_DZ_FLAG_EN
    logic         dz;
`endif

    modport master (
        output start, x, y,
        input  busy, valid, q, r
`ifdef BOOTH_DIV_DZ_FLAG_EN
        , input dz
`endif
    );

    modport slave (
        input  start, x, y,
        output busy, valid, q, r
`ifdef BOOTH_DIV_DZ_FLAG_EN
        , output dz
`endif
    );
endinterface

// File: rtl/booth_div_step.sv
// One combinational restoring-division iteration on operand magnitudes.
// Shifts the next dividend bit into the partial remainder and trial-subtracts |Y| in W+1 bits.
module booth_div_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_ymag,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);
    logic [W:0] w_shift;
    logic [W:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_ymag};

    // A set top bit means the trial went negative: restore the shifted value.
    assign o_qbit = ~w_diff[W];
    assign o_rem  = w_diff[W] ? w_shift[W-1:0] : w_diff[W-1:0];
endmodule

// File: rtl/booth_div.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock, then sign fix-up.
// Optional divide-by-zero flag output enabled by defining BOOTH_DIV_DZ_FLAG_EN.
module booth_div
    import booth_div_pkg::*;
#(
    parameter int W = 4
) (
    input logic          clk,
    input logic          rst,
    booth_div_if.slave   bus
);
    localparam int CNT_W = cnt_w(W);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_dvd;
    logic [W-1:0]     r_ymag;
    logic             r_xs;
    logic             r_ys;
    logic             r_yz;
    logic [W-1:0]     r_q;
    logic [W-1:0]     r_r;
    logic             r_valid;
`ifdef BOOTH_DIV_DZ_FLAG_EN
    logic             r_dz;
`endif

    logic [W-1:0]     w_xmag;
    logic [W-1:0]     w_ymag;
    logic [W-1:0]     w_rem_nxt;
    logic             w_qbit;
    logic             w_last;
    logic [W-1:0]     w_q_fix;
    logic [W-1:0]     w_r_fix;

    assign w_xmag = bus.x[W-1] ? (-bus.x) : bus.x;
    assign w_ymag = bus.y[W-1] ? (-bus.y) : bus.y;
    assign w_last = (r_cnt == CNT_W'(W - 1));

    booth_div_step #(.W(W)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd[W-1]),
        .i_ymag (r_ymag),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    // With Y==0 every trial succeeds, so the remainder ends as |X| and R = X falls out of the sign step.
    assign w_q_fix = r_yz ? DZ_Q_ONES[W-1:0] : ((r_xs ^ r_ys) ? (-r_dvd) : r_dvd);
    assign w_r_fix = r_xs ? (-r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = CALC;
            CALC:    if (w_last) w_next = SIGN;
            SIGN:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_ymag  <= '0;
            r_xs    <= 1'b0;
            r_ys    <= 1'b0;
            r_yz    <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_valid <= 1'b0;
`ifdef BOOTH_DIV_DZ_FLAG_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dvd  <= w_xmag;
                        r_ymag <= w_ymag;
                        r_xs   <= bus.x[W-1];
                        r_ys   <= bus.y[W-1];
                        r_yz   <= (bus.y == '0);
                        r_rem  <= '0;
                        r_cnt  <= '0;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[W-2:0], w_qbit};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                SIGN: begin
                    r_q     <= w_q_fix;
                    r_r     <= w_r_fix;
                    r_valid <= 1'b1;
`ifdef BOOTH_DIV_DZ_FLAG_EN
                    r_dz    <= r_yz;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (r_state != IDLE);
    assign bus.valid = r_valid;
    assign bus.q     = r_q;
    assign bus.r     = r_r;
`ifdef BOOTH_DIV_DZ_FLAG_EN
    assign bus.dz    = r_dz;
`endif
endmodule

// File: tb/tb_booth_div.sv
// Self-checking bench for booth_div (W=4): vector table, random ops against an integer model, corner sequences.
// dz checks are compiled in only when BOOTH_DIV_DZ_FLAG_EN is defined.
module tb_booth_div;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    booth_div_if #(.W(W)) bus ();

    booth_div #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: C-style truncating division; divide-by-zero gives -1 and X.
    function automatic int ref_q(input int a, input int b);
        if (b == 0) return -1;
        return a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        if (b == 0) return a;
        return a % b;
    endfunction

    task automatic do_div(input int a, input int b, input string tag,
                          output logic [W-1:0] q, output logic [W-1:0] r);
        int n;
        bit got;
        bus.x     = W'(a);
        bus.y     = W'(b);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.x     = W'($urandom);
        bus.y     = W'($urandom);
        check({tag, "/busy_e0"}, 32'(bus.busy), 32'd1);
        n   = 0;
        got = 1'b0;
        while (!got && n < 12) begin
            tick();
            n++;
            if (bus.valid) got = 1'b1;
        end
        check({tag, "/latency"}, 32'(n), 32'd5);
        check({tag, "/busy_at_valid"}, 32'(bus.busy), 32'd0);
        q = bus.q;
        r = bus.r;
        tick();
        check({tag, "/valid_one_cycle"}, 32'(bus.valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] q;
        logic [W-1:0] r;
        int a;
        int b;
        int eq;
        int er;

        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        rst       = 1'b0;
        repeat (3) tick();
        check("reset/busy",  32'(bus.busy),  32'd0);
        check("reset/valid", 32'(bus.valid), 32'd0);
        check("reset/q",     32'(bus.q),     32'd0);
        check("reset/r",     32'(bus.r),     32'd0);
`ifdef BOOTH_DIV_DZ_FLAG_EN
        check("reset/dz",    32'(bus.dz),    32'd0);
`endif
        rst = 1'b1;
        tick();

        vecs[0] = '{ 7,  2,  3,  1};
        vecs[1] = '{-7,  2, -3, -1};
        vecs[2] = '{ 7, -2, -3,  1};
        vecs[3] = '{-7, -2,  3, -1};
        vecs[4] = '{-8, -1, -8,  0};
        vecs[5] = '{-8,  1, -8,  0};
        vecs[6] = '{ 0,  5,  0,  0};
        vecs[7] = '{ 5,  0, -1,  5};
        vecs[8] = '{ 6,  4,  1,  2};

        for (int i = 0; i < 9; i++) begin
            eq = vecs[i].q & 15;
            er = vecs[i].r & 15;
            do_div(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), q, r);
            check($sformatf("vec%0d/q", i), 32'(q), 32'(eq));
            check($sformatf("vec%0d/r", i), 32'(r), 32'(er));
`ifdef BOOTH_DIV_DZ_FLAG_EN
            check($sformatf("vec%0d/dz", i), 32'(bus.dz), 32'(vecs[i].b == 0));
`endif
        end

        for (int i = 0; i < 40; i++) begin
            a  = int'($urandom_range(0, 15)) - 8;
            b  = int'($urandom_range(0, 15)) - 8;
            eq = ref_q(a, b) & 15;
            er = ref_r(a, b) & 15;
            do_div(a, b, $sformatf("rnd%0d", i), q, r);
            check($sformatf("rnd%0d/q(%0d/%0d)", i, a, b), 32'(q), 32'(eq));
            check($sformatf("rnd%0d/r(%0d/%0d)", i, a, b), 32'(r), 32'(er));
`ifdef BOOTH_DIV_DZ_FLAG_EN
            check($sformatf("rnd%0d/dz", i), 32'(bus.dz), 32'(b == 0));
`endif
        end

        // Start while busy is ignored; start in the valid cycle is accepted.
        bus.x = 4'd7; bus.y = 4'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.x = 4'd1; bus.y = 4'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("seqA/no_early_valid", 32'(bus.valid), 32'd0);
        tick();
        check("seqA/valid1", 32'(bus.valid), 32'd1);
        check("seqA/q1", 32'(bus.q), 32'd3);
        check("seqA/r1", 32'(bus.r), 32'd1);
        bus.x = 4'd6; bus.y = 4'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("seqA/busy_b2b", 32'(bus.busy), 32'd1);
        check("seqA/valid_drop", 32'(bus.valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("seqA/quiet%0d", k), 32'(bus.valid), 32'd0);
        end
        tick();
        check("seqA/valid2", 32'(bus.valid), 32'd1);
        check("seqA/q2", 32'(bus.q), 32'd2);
        check("seqA/r2", 32'(bus.r), 32'd0);
        tick();

        // Reset mid-CALC drops the operation.
        bus.x = 4'd7; bus.y = 4'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("seqB/busy", 32'(bus.busy), 32'd0);
        check("seqB/q", 32'(bus.q), 32'd0);
        check("seqB/r", 32'(bus.r), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("seqB/no_valid%0d", k), 32'(bus.valid), 32'd0);
        end
        do_div(6, 4, "seqB/after", q, r);
        check("seqB/after_q", 32'(q), 32'd1);
        check("seqB/after_r", 32'(r), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
